// File: rtl/tile_fetch_sequencer.sv
// rtl/tile_fetch_sequencer.sv - background tile fetch sequencer: VRAM map fetch, ROM plane read, shifter load control
module tile_fetch_sequencer #(
   parameter int CODE_W    = 11,
   parameter int COLS_LOG2 = 5
) (
   input  logic                   clk,
   input  logic                   n_clr,
   input  logic                   pix_ce,
   input  logic [8:0]             h_cnt,
   input  logic [7:0]             v_cnt,
   input  logic                   fetch_en,
   output logic                   vram_req,
   output logic [5+COLS_LOG2-1:0] vram_addr,
   input  logic                   vram_ack,
   input  logic [15:0]            vram_data,
   output logic [CODE_W+2:0]      rom_addr,
   input  logic [15:0]            rom_data,
   output logic [7:0]             d1_out,
   output logic [7:0]             d2_out,
   output logic                   shift_ld,
   output logic                   sel,
   output logic [3:0]             pal_out,
   output logic [7:0]             underrun_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, ROM_RD, READY} state_t;

   state_t                   state_q, state_d;
   logic                     vram_req_q, vram_req_d;
   logic [5+COLS_LOG2-1:0]   vram_addr_q, vram_addr_d;
   logic [CODE_W+2:0]        rom_addr_q, rom_addr_d;
   logic [7:0]               p0_stg_q, p0_stg_d;
   logic [7:0]               p1_stg_q, p1_stg_d;
   logic                     flip_stg_q, flip_stg_d;
   logic [3:0]               pal_stg_q, pal_stg_d;
   logic                     blank_q, blank_d;
   logic [7:0]               d1_q, d1_d;
   logic [7:0]               d2_q, d2_d;
   logic                     sel_q, sel_d;
   logic [3:0]               pal_q, pal_d;
   logic                     shift_ld_q, shift_ld_d;
   logic [7:0]               under_q, under_d;

   logic                     load_evt;
   logic                     start_evt;
   logic [COLS_LOG2-1:0]     col;
   logic                     unused_h;

   assign load_evt  = pix_ce && (h_cnt[2:0] == 3'd7);
   assign start_evt = pix_ce && (h_cnt[2:0] == 3'd0);
   // The tile fetched now is the one displayed in the next 8-pixel group.
   assign col       = h_cnt[3 +: COLS_LOG2] + {{(COLS_LOG2-1){1'b0}}, 1'b1};
   // Top counter bit only distinguishes the blanking half of the line.
   assign unused_h  = h_cnt[8];

   // Next-state and output decode; the load event overrides any fetch activity.
   always_comb begin
      state_d     = state_q;
      vram_req_d  = vram_req_q;
      vram_addr_d = vram_addr_q;
      rom_addr_d  = rom_addr_q;
      p0_stg_d    = p0_stg_q;
      p1_stg_d    = p1_stg_q;
      flip_stg_d  = flip_stg_q;
      pal_stg_d   = pal_stg_q;
      blank_d     = blank_q;
      d1_d        = d1_q;
      d2_d        = d2_q;
      sel_d       = sel_q;
      pal_d       = pal_q;
      shift_ld_d  = 1'b1;
      under_d     = under_q;

      if (load_evt) begin
         shift_ld_d = 1'b0;
         vram_req_d = 1'b0;
         state_d    = IDLE;
         if (state_q == READY) begin
            d1_d  = p0_stg_q;
            d2_d  = p1_stg_q;
            sel_d = flip_stg_q;
            pal_d = pal_stg_q;
         end else begin
            d1_d  = 8'h00;
            d2_d  = 8'h00;
            sel_d = 1'b0;
            pal_d = 4'h0;
            if (!blank_q && (under_q != 8'hFF)) begin
               under_d = under_q + 8'd1;
            end
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (start_evt) begin
                  blank_d = !fetch_en;
                  if (fetch_en) begin
                     vram_addr_d = {v_cnt[7:3], col};
                     vram_req_d  = 1'b1;
                     state_d     = WAIT_ACK;
                  end
               end
            end
            WAIT_ACK: begin
               if (vram_ack) begin
                  flip_stg_d = vram_data[11];
                  pal_stg_d  = vram_data[15:12];
                  rom_addr_d = {vram_data[CODE_W-1:0], v_cnt[2:0]};
                  vram_req_d = 1'b0;
                  state_d    = ROM_RD;
               end
            end
            ROM_RD: begin
               p0_stg_d = rom_data[7:0];
               p1_stg_d = rom_data[15:8];
               state_d  = READY;
            end
            default: begin
               state_d = READY;
            end
         endcase
      end
   end

   // State and output registers; blank_q resets set so the first load after reset is not an underrun.
   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         state_q     <= IDLE;
         vram_req_q  <= 1'b0;
         vram_addr_q <= '0;
         rom_addr_q  <= '0;
         p0_stg_q    <= 8'h00;
         p1_stg_q    <= 8'h00;
         flip_stg_q  <= 1'b0;
         pal_stg_q   <= 4'h0;
         blank_q     <= 1'b1;
         d1_q        <= 8'h00;
         d2_q        <= 8'h00;
         sel_q       <= 1'b0;
         pal_q       <= 4'h0;
         shift_ld_q  <= 1'b1;
         under_q     <= 8'h00;
      end else begin
         state_q     <= state_d;
         vram_req_q  <= vram_req_d;
         vram_addr_q <= vram_addr_d;
         rom_addr_q  <= rom_addr_d;
         p0_stg_q    <= p0_stg_d;
         p1_stg_q    <= p1_stg_d;
         flip_stg_q  <= flip_stg_d;
         pal_stg_q   <= pal_stg_d;
         blank_q     <= blank_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         sel_q       <= sel_d;
         pal_q       <= pal_d;
         shift_ld_q  <= shift_ld_d;
         under_q     <= under_d;
      end
   end

   assign vram_req     = vram_req_q;
   assign vram_addr    = vram_addr_q;
   assign rom_addr     = rom_addr_q;
   assign d1_out       = d1_q;
   assign d2_out       = d2_q;
   assign shift_ld     = shift_ld_q;
   assign sel          = sel_q;
   assign pal_out      = pal_q;
   assign underrun_cnt = under_q;

endmodule

// File: tb/tb_tile_fetch_sequencer.sv
// tb/tb_tile_fetch_sequencer.sv - directed vector bench for tile_fetch_sequencer
module tb_tile_fetch_sequencer;

   logic        clk = 1'b0;
   logic        n_clr;
   logic        pix_ce;
   logic [8:0]  h_cnt;
   logic [7:0]  v_cnt;
   logic        fetch_en;
   logic        vram_req;
   logic [9:0]  vram_addr;
   logic        vram_ack;
   logic [15:0] vram_data;
   logic [13:0] rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  d1_out;
   logic [7:0]  d2_out;
   logic        shift_ld;
   logic        sel;
   logic [3:0]  pal_out;
   logic [7:0]  underrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_cnt = 0;

   tile_fetch_sequencer #(.CODE_W(11), .COLS_LOG2(5)) dut (
      .clk          (clk),
      .n_clr        (n_clr),
      .pix_ce       (pix_ce),
      .h_cnt        (h_cnt),
      .v_cnt        (v_cnt),
      .fetch_en     (fetch_en),
      .vram_req     (vram_req),
      .vram_addr    (vram_addr),
      .vram_ack     (vram_ack),
      .vram_data    (vram_data),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .d1_out       (d1_out),
      .d2_out       (d2_out),
      .shift_ld     (shift_ld),
      .sel          (sel),
      .pal_out      (pal_out),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   // ack_ph: phase whose clk carries the ack; 8 = one clk after the load, 9 = never
   typedef struct {
      logic [8:0]  h_base;
      logic [7:0]  v;
      logic        fen;
      int          ack_ph;
      logic [15:0] vdata;
      logic [15:0] rdata;
      logic [9:0]  exp_vaddr;
      logic [13:0] exp_raddr;
      logic [7:0]  exp_d1;
      logic [7:0]  exp_d2;
      logic        exp_sel;
      logic [3:0]  exp_pal;
      logic        exp_under;
   } vec_t;

   vec_t vecs[9];
   vec_t sat_vec;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t t);
      for (int p = 0; p < 8; p++) begin
         pix_ce    = 1'b1;
         h_cnt     = t.h_base + 9'(p);
         v_cnt     = t.v;
         fetch_en  = t.fen;
         rom_data  = t.rdata;
         vram_ack  = (p == t.ack_ph);
         vram_data = (p == t.ack_ph) ? t.vdata : 16'hDEAD;
         step();
         if (p == 0) begin
            chk("req_after_start", {31'd0, vram_req}, {31'd0, t.fen});
            if (t.fen) chk("vram_addr", {22'd0, vram_addr}, {22'd0, t.exp_vaddr});
         end
         if (t.fen && (p == t.ack_ph) && (p <= 6)) begin
            chk("rom_addr", {18'd0, rom_addr}, {18'd0, t.exp_raddr});
            chk("req_after_ack", {31'd0, vram_req}, 32'd0);
         end
         if (p < 7) chk("shift_ld_idle", {31'd0, shift_ld}, 32'd1);
      end
      if (t.exp_under && exp_cnt < 255) exp_cnt++;
      chk("shift_ld_load", {31'd0, shift_ld}, 32'd0);
      chk("d1_out", {24'd0, d1_out}, {24'd0, t.exp_d1});
      chk("d2_out", {24'd0, d2_out}, {24'd0, t.exp_d2});
      chk("sel", {31'd0, sel}, {31'd0, t.exp_sel});
      chk("pal_out", {28'd0, pal_out}, {28'd0, t.exp_pal});
      chk("req_after_load", {31'd0, vram_req}, 32'd0);
      chk("underrun_cnt", {24'd0, underrun_cnt}, exp_cnt);
      pix_ce    = 1'b0;
      h_cnt     = t.h_base + 9'd8;
      vram_ack  = (t.ack_ph == 8);
      vram_data = 16'h1234;
      step();
      vram_ack  = 1'b0;
      chk("shift_ld_after", {31'd0, shift_ld}, 32'd1);
      chk("req_late_ack", {31'd0, vram_req}, 32'd0);
      chk("d1_hold", {24'd0, d1_out}, {24'd0, t.exp_d1});
      chk("cnt_hold", {24'd0, underrun_cnt}, exp_cnt);
   endtask

   initial begin
      vecs[0] = '{9'h010, 8'h2B, 1'b1, 3, 16'h5923, 16'hA55A, 10'h0A3, 14'h091B, 8'h5A, 8'hA5, 1'b1, 4'h5, 1'b0};
      vecs[1] = '{9'h0F8, 8'h47, 1'b1, 1, 16'h2045, 16'h3C81, 10'h100, 14'h022F, 8'h81, 8'h3C, 1'b0, 4'h2, 1'b0};
      vecs[2] = '{9'h1E0, 8'hFF, 1'b1, 5, 16'hFFFF, 16'h0001, 10'h3FD, 14'h3FFF, 8'h01, 8'h00, 1'b1, 4'hF, 1'b0};
      vecs[3] = '{9'h100, 8'h10, 1'b1, 2, 16'h7400, 16'hFF00, 10'h041, 14'h2000, 8'h00, 8'hFF, 1'b0, 4'h7, 1'b0};
      vecs[4] = '{9'h048, 8'h2B, 1'b0, 9, 16'h0000, 16'hFFFF, 10'h000, 14'h0000, 8'h00, 8'h00, 1'b0, 4'h0, 1'b0};
      vecs[5] = '{9'h050, 8'h2B, 1'b1, 4, 16'hC8A7, 16'h6699, 10'h0AB, 14'h053B, 8'h99, 8'h66, 1'b1, 4'hC, 1'b0};
      vecs[6] = '{9'h020, 8'h2B, 1'b1, 6, 16'h5923, 16'hA55A, 10'h0A5, 14'h091B, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1};
      vecs[7] = '{9'h038, 8'h08, 1'b1, 7, 16'h1111, 16'h2222, 10'h028, 14'h0000, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1};
      vecs[8] = '{9'h040, 8'h08, 1'b1, 8, 16'h5923, 16'hA55A, 10'h029, 14'h0000, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1};
      sat_vec = '{9'h068, 8'h2B, 1'b1, 9, 16'h0000, 16'h0000, 10'h0AE, 14'h0000, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1};

      n_clr = 1'b0; pix_ce = 1'b0; h_cnt = '0; v_cnt = '0; fetch_en = 1'b0;
      vram_ack = 1'b0; vram_data = '0; rom_data = '0;
      repeat (3) step();
      chk("rst_req", {31'd0, vram_req}, 32'd0);
      chk("rst_shift_ld", {31'd0, shift_ld}, 32'd1);
      chk("rst_outs", {6'd0, vram_addr, d1_out, d2_out}, 32'd0);
      chk("rst_cnt", {24'd0, underrun_cnt}, 32'd0);
      n_clr = 1'b1;
      step();

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Asynchronous reset while waiting for the VRAM grant
      pix_ce = 1'b1; fetch_en = 1'b1; v_cnt = 8'h2B; h_cnt = 9'h060;
      step();
      chk("pre_rst_req", {31'd0, vram_req}, 32'd1);
      h_cnt = 9'h061;
      step();
      #2;
      n_clr = 1'b0;
      #1;
      chk("async_req", {31'd0, vram_req}, 32'd0);
      chk("async_shift_ld", {31'd0, shift_ld}, 32'd1);
      chk("async_outs", {2'd0, rom_addr, sel, pal_out, d1_out, d2_out[4:0]}, 32'd0);
      chk("async_addr", {14'd0, vram_addr, d2_out}, 32'd0);
      chk("async_cnt", {24'd0, underrun_cnt}, 32'd0);
      exp_cnt = 0;
      pix_ce = 1'b0;
      step();
      n_clr = 1'b1;
      step();

      // Counter saturation over a long run of starved groups
      for (int i = 0; i < 260; i++) run_vec(sat_vec);
      chk("sat_cnt", {24'd0, underrun_cnt}, 32'd255);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
